// File: rtl/memory_access_responder.sv
// Simulation-only backing memory: line read/write, fixed-latency read pipeline, response FIFO.
// Optional MEM_RESPONDER_BYTE_MASK_EN enables byte-masked writes; RSD_SYNTHESIS rejects the build.
module memory_access_responder #(
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned LINE_WIDTH     = 128,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SERIAL_WIDTH   = 4,
    parameter int unsigned READ_LATENCY   = 3,
    parameter int unsigned RSP_QUEUE_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_is_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [LINE_WIDTH-1:0]   req_wdata,
    input  logic [LINE_WIDTH/8-1:0] req_byte_en,
    input  logic [SERIAL_WIDTH-1:0] req_serial,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [LINE_WIDTH-1:0]   rsp_data,
    output logic [SERIAL_WIDTH-1:0] rsp_serial,
    output logic                    wr_ack_valid,
    output logic [SERIAL_WIDTH-1:0] wr_ack_serial,
    output logic                    overflow_err
);

`ifdef RSD_SYNTHESIS
    $error("memory_access_responder is a simulation-only model");
`endif

    localparam int unsigned NB   = LINE_WIDTH / 8;
    localparam int unsigned OFS  = $clog2(NB);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned QW   = $clog2(RSP_QUEUE_SIZE);
    localparam int unsigned L    = READ_LATENCY;

    logic [LINE_WIDTH-1:0] mem [DEPTH];
    logic [IDXW-1:0]       idx;

    // Only the index field of the byte address selects a line; the rest wraps away.
    assign idx = req_addr[OFS +: IDXW];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:OFS+IDXW], req_addr[OFS-1:0]};

    always_ff @(posedge clk) begin
        if (!rst && req_valid && req_is_write) begin
`ifdef MEM_RESPONDER_BYTE_MASK_EN
            for (int b = 0; b < NB; b++) begin
                if (req_byte_en[b]) begin
                    mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
`else
            mem[idx] <= req_wdata;
`endif
        end
    end

`ifndef MEM_RESPONDER_BYTE_MASK_EN
    logic unused_byte_en;
    assign unused_byte_en = ^req_byte_en;
`endif

    // Write acknowledge
    logic                    ack_valid_q;
    logic [SERIAL_WIDTH-1:0] ack_serial_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_valid_q <= 1'b0;
        end else begin
            ack_valid_q <= req_valid && req_is_write;
        end
        ack_serial_q <= req_serial;
    end

    assign wr_ack_valid  = ack_valid_q;
    assign wr_ack_serial = ack_serial_q;

    // Read pipeline: never stalls, stage 0 holds the line read at the accepting edge.
    logic [L-1:0]            stage_valid_q;
    logic [LINE_WIDTH-1:0]   stage_data_q   [L];
    logic [SERIAL_WIDTH-1:0] stage_serial_q [L];

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= '0;
        end else begin
            stage_valid_q[0] <= req_valid && !req_is_write;
            for (int k = 1; k < L; k++) begin
                stage_valid_q[k] <= stage_valid_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        stage_data_q[0]   <= mem[idx];
        stage_serial_q[0] <= req_serial;
        for (int k = 1; k < L; k++) begin
            stage_data_q[k]   <= stage_data_q[k-1];
            stage_serial_q[k] <= stage_serial_q[k-1];
        end
    end

    // Response queue
    logic [LINE_WIDTH-1:0]   q_data   [RSP_QUEUE_SIZE];
    logic [SERIAL_WIDTH-1:0] q_serial [RSP_QUEUE_SIZE];
    logic [QW-1:0]           head_q, tail_q;
    logic [QW:0]             count_q, count_d;
    logic                    ovf_q;
    logic                    q_full, push, pop, push_ok, drop;

    assign q_full  = (count_q == (QW+1)'(RSP_QUEUE_SIZE));
    assign pop     = (count_q != '0) && rsp_ready;
    assign push    = stage_valid_q[L-1];
    // A simultaneous pop frees the slot, so a full queue still accepts the push.
    assign push_ok = push && (!q_full || pop);
    assign drop    = push && q_full && !pop;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_data[tail_q]   <= stage_data_q[L-1];
            q_serial[tail_q] <= stage_serial_q[L-1];
        end
    end

    assign rsp_valid    = (count_q != '0);
    assign rsp_data     = q_data[head_q];
    assign rsp_serial   = q_serial[head_q];
    assign overflow_err = ovf_q;

    assert property (@(posedge clk) disable iff (rst) !drop)
        else $warning("memory_access_responder: read response dropped, queue full");

endmodule
